uart_rx_os: RTL

//   Standalone UART receiver: 16x oversampled, majority-vote sampling, framing/overrun detection.

---
 rtl/uart_rx_os.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_os.sv
// 16x oversampled UART receiver with 3-sample majority vote, framing and overrun
// detection, presenting received bytes through a valid/ready holding register.
module uart_rx_os #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SC_W  = $clog2(OVERSAMPLE);
    localparam int BI_W  = $clog2(DATA_BITS);
    localparam int M     = OVERSAMPLE / 2;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);
    localparam logic [SC_W-1:0]  SC_S0    = SC_W'(M - 1);
    localparam logic [SC_W-1:0]  SC_S1    = SC_W'(M);
    localparam logic [SC_W-1:0]  SC_EVAL  = SC_W'(M + 1);
    localparam logic [BI_W-1:0]  BI_LAST  = BI_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t state_q, state_d;

    logic                 sync1_q, sync2_q;
    logic [DIV_W-1:0]     divCnt_q;
    logic [SC_W-1:0]      scnt_q;
    logic [BI_W-1:0]      bitIdx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 samp0_q, samp1_q;
    logic                 deliver_q;
    logic                 frameErr_q;
    logic                 overrunErr_q;
    logic [DATA_BITS-1:0] rxData_q;
    logic                 rxValid_q;

    logic rxS;
    logic tick;
    logic evalTick;
    logic bitEnd;
    logic vote;
    logic shiftEn;
    logic stopOk;
    logic stopBad;

    assign rxS      = sync2_q;
    assign tick     = (divCnt_q == DIV_LAST);
    assign evalTick = tick && (scnt_q == SC_EVAL);
    assign bitEnd   = tick && (scnt_q == SC_LAST);
    assign vote     = (samp0_q & samp1_q) | (samp0_q & rxS) | (samp1_q & rxS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shiftEn = 1'b0;
        stopOk  = 1'b0;
        stopBad = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxS) begin
                    state_d = START;
                end
            end
            START: begin
                if (evalTick && vote) begin
                    state_d = IDLE;
                end else if (bitEnd) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                shiftEn = evalTick;
                if (bitEnd && (bitIdx_q == BI_LAST)) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // Leave mid-stop-bit so a start edge right after the stop bit is caught.
                if (evalTick) begin
                    if (vote) begin
                        stopOk  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stopBad = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                if (tick && rxS) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Divider and sample counter sit at zero while idle, so each frame starts aligned to its start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divCnt_q <= '0;
            scnt_q   <= '0;
            bitIdx_q <= '0;
            samp0_q  <= 1'b1;
            samp1_q  <= 1'b1;
            shift_q  <= '0;
        end else begin
            if (state_q == IDLE) begin
                divCnt_q <= '0;
                scnt_q   <= '0;
                bitIdx_q <= '0;
            end else begin
                if (tick) begin
                    divCnt_q <= '0;
                    scnt_q   <= (scnt_q == SC_LAST) ? '0 : scnt_q + SC_W'(1);
                end else begin
                    divCnt_q <= divCnt_q + DIV_W'(1);
                end
                if (state_q == DATA && bitEnd) begin
                    bitIdx_q <= bitIdx_q + BI_W'(1);
                end
            end
            if (tick && (scnt_q == SC_S0)) begin
                samp0_q <= rxS;
            end
            if (tick && (scnt_q == SC_S1)) begin
                samp1_q <= rxS;
            end
            if (shiftEn) begin
                shift_q <= {vote, shift_q[DATA_BITS-1:1]};
            end
        end
    end

    // A delivery into a full register is only accepted if the consumer drains it the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deliver_q    <= 1'b0;
            frameErr_q   <= 1'b0;
            overrunErr_q <= 1'b0;
            rxData_q     <= '0;
            rxValid_q    <= 1'b0;
        end else begin
            deliver_q    <= stopOk;
            frameErr_q   <= stopBad;
            overrunErr_q <= 1'b0;
            if (deliver_q) begin
                if (!rxValid_q || rx_ready) begin
                    rxData_q  <= shift_q;
                    rxValid_q <= 1'b1;
                end else begin
                    overrunErr_q <= 1'b1;
                end
            end else if (rxValid_q && rx_ready) begin
                rxValid_q <= 1'b0;
            end
        end
    end

    assign rx_data     = rxData_q;
    assign rx_valid    = rxValid_q;
    assign frame_err   = frameErr_q;
    assign overrun_err = overrunErr_q;
    assign busy        = (state_q != IDLE);

endmodule
